// File: rtl/fetch_stage_if.sv
// ============================================================================
// Module : fetch_stage_if
// Instruction-memory request/response channel between fetch and imem.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rvalid, imem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module : fetch_stage
// RV32I fetch: sequential PC, credit-limited imem requests, response FIFO,
// IF/ID register with stall / flush / redirect.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fetch_stage #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 2,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] NOP_INSTR       = 32'h0000_0013
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        keep,
  input  wire logic        nop,
  input  wire logic        redirect_valid,
  input  wire logic [31:0] redirect_pc,
  fetch_stage_if.master    imem,
  output logic [31:0]      PC_pype0,
  output logic [31:0]      PCp4_pype0,
  output logic [31:0]      Instraction_pype,
  output logic             fetch_valid
);

  localparam int         FAW       = $clog2(FIFO_DEPTH);
  localparam int         PQW       = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [7:0] C_FD      = 8'(FIFO_DEPTH);
  localparam logic [7:0] C_MO      = 8'(MAX_OUTSTANDING);
  localparam logic [PQW-1:0] C_PQ_LAST = PQW'(MAX_OUTSTANDING - 1);

  logic [31:0]    r_fetch_pc;
  logic [7:0]     r_o;
  logic [7:0]     r_d;
  logic [7:0]     r_c;
  logic [31:0]    r_pcq [MAX_OUTSTANDING];
  logic [PQW-1:0] r_pcq_wr;
  logic [PQW-1:0] r_pcq_rd;
  logic [31:0]    r_fifo_pc  [FIFO_DEPTH];
  logic [31:0]    r_fifo_ins [FIFO_DEPTH];
  logic [FAW-1:0] r_fwr;
  logic [FAW-1:0] r_frd;

  logic [7:0]  w_credit;
  logic        w_accept;
  logic        w_resp;
  logic        w_drop;
  logic        w_deliver;
  logic [31:0] w_resp_pc;
  logic [31:0] w_target;
  logic        w_push;
  logic        w_pop;
  logic        w_ld_bubble;
  logic        w_ld_head;
  logic        w_ld_bypass;

  // Responses already counted as "to drop" do not consume FIFO credit.
  assign w_credit  = r_o - r_d + r_c;
  assign imem.imem_req  = !rst && !redirect_valid && (w_credit < C_FD) && (r_o < C_MO);
  assign imem.imem_addr = r_fetch_pc;

  assign w_accept  = imem.imem_req && imem.imem_ready;
  assign w_resp    = imem.imem_rvalid && (r_o != 8'd0);
  assign w_drop    = (r_d != 8'd0);
  assign w_deliver = w_resp && !w_drop && !redirect_valid;
  assign w_resp_pc = r_pcq[r_pcq_rd];
  assign w_target  = redirect_pc & ~32'h3;

  always_comb begin
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_ld_bubble = 1'b0;
    w_ld_head   = 1'b0;
    w_ld_bypass = 1'b0;
    if (redirect_valid) begin
      w_ld_bubble = 1'b1;
    end else if (nop) begin
      w_ld_bubble = 1'b1;
      w_pop       = (r_c != 8'd0);
      w_push      = w_deliver;
    end else if (keep) begin
      w_push = w_deliver;
    end else if (r_c != 8'd0) begin
      w_ld_head = 1'b1;
      w_pop     = 1'b1;
      w_push    = w_deliver;
    end else if (w_deliver) begin
      w_ld_bypass = 1'b1;
    end else begin
      w_ld_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_o        <= 8'd0;
      r_d        <= 8'd0;
      r_c        <= 8'd0;
      r_pcq_wr   <= '0;
      r_pcq_rd   <= '0;
      r_fwr      <= '0;
      r_frd      <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc <= w_target;
      r_o        <= r_o - {7'd0, w_resp};
      r_d        <= r_o - {7'd0, w_resp};
      r_c        <= 8'd0;
      r_pcq_wr   <= '0;
      r_pcq_rd   <= '0;
      r_fwr      <= '0;
      r_frd      <= '0;
    end else begin
      if (w_accept) begin
        r_fetch_pc        <= r_fetch_pc + 32'd4;
        r_pcq[r_pcq_wr]   <= r_fetch_pc;
        r_pcq_wr          <= (r_pcq_wr == C_PQ_LAST) ? '0 : r_pcq_wr + PQW'(1);
      end
      if (w_resp && !w_drop) begin
        r_pcq_rd <= (r_pcq_rd == C_PQ_LAST) ? '0 : r_pcq_rd + PQW'(1);
      end
      r_o <= r_o + {7'd0, w_accept} - {7'd0, w_resp};
      r_d <= r_d - {7'd0, (w_resp && w_drop)};
      if (w_push) begin
        r_fifo_pc[r_fwr]  <= w_resp_pc;
        r_fifo_ins[r_fwr] <= imem.imem_rdata;
        r_fwr             <= r_fwr + FAW'(1);
      end
      if (w_pop) begin
        r_frd <= r_frd + FAW'(1);
      end
      r_c <= r_c + {7'd0, w_push} - {7'd0, w_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_ld_bubble) begin
      PC_pype0         <= 32'd0;
      PCp4_pype0       <= 32'd0;
      Instraction_pype <= NOP_INSTR;
      fetch_valid      <= 1'b0;
    end else if (w_ld_head) begin
      PC_pype0         <= r_fifo_pc[r_frd];
      PCp4_pype0       <= r_fifo_pc[r_frd] + 32'd4;
      Instraction_pype <= r_fifo_ins[r_frd];
      fetch_valid      <= 1'b1;
    end else if (w_ld_bypass) begin
      PC_pype0         <= w_resp_pc;
      PCp4_pype0       <= w_resp_pc + 32'd4;
      Instraction_pype <= imem.imem_rdata;
      fetch_valid      <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module : tb_fetch_stage
// Scoreboard bench for fetch_stage with an in-order variable-latency memory.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_stage;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          FD     = 2;
  localparam int          MO     = 2;
  localparam logic [31:0] NOPI   = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        keep;
  logic        nop;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] PC_pype0;
  logic [31:0] PCp4_pype0;
  logic [31:0] Instraction_pype;
  logic        fetch_valid;

  fetch_stage_if ifc ();

  fetch_stage #(
    .RESET_PC(RST_PC), .FIFO_DEPTH(FD), .MAX_OUTSTANDING(MO), .NOP_INSTR(NOPI)
  ) dut (
    .clk(clk), .rst(rst), .keep(keep), .nop(nop),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem(ifc.master),
    .PC_pype0(PC_pype0), .PCp4_pype0(PCp4_pype0),
    .Instraction_pype(Instraction_pype), .fetch_valid(fetch_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; bit st; } inf_t;
  typedef struct { logic [31:0] pc; logic [31:0] ins; } av_t;
  typedef struct { bit upd; bit rs; bit v; logic [31:0] pc; logic [31:0] ins; } exp_t;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mq [$];
  inf_t        m_if [$];
  av_t         m_av [$];
  exp_t        exp_q [$];
  logic [31:0] m_fpc;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endfunction

  task automatic step(input bit r, input bit rd, input logic [31:0] rp, input bit n,
                      input bit k, input bit rdy, input int rvp);
    bit   rv;
    bit   exp_req;
    bit   acc;
    bit   dacc;
    bit   dlv;
    int   live;
    inf_t e;
    av_t  arr;
    av_t  hd;
    exp_t x;
    @(negedge clk);
    rst = r; redirect_valid = rd; redirect_pc = rp; nop = n; keep = k;
    ifc.imem_ready  = rdy;
    rv              = (mq.size() > 0) && ($urandom_range(99) < rvp);
    ifc.imem_rvalid = rv;
    ifc.imem_rdata  = rv ? mem(mq[0]) : $urandom;
    #1;
    dacc = ifc.imem_req && rdy;
    x.upd = 1'b1; x.rs = 1'b0; x.v = 1'b0; x.pc = 32'd0; x.ins = NOPI;
    if (r) begin
      chk("imem_req_in_rst", {31'd0, ifc.imem_req}, 32'd0);
      m_fpc = RST_PC;
      m_if.delete();
      m_av.delete();
      x.rs = 1'b1;
    end else begin
      live = 0;
      foreach (m_if[i]) if (!m_if[i].st) live++;
      exp_req = !rd && (live + m_av.size() < FD) && (m_if.size() < MO);
      chk("imem_req", {31'd0, ifc.imem_req}, {31'd0, exp_req});
      acc = exp_req && rdy;
      if (acc) chk("imem_addr", ifc.imem_addr, m_fpc);
      dlv = 1'b0;
      arr.pc = 32'd0; arr.ins = 32'd0;
      if (rv && m_if.size() > 0) begin
        e       = m_if.pop_front();
        dlv     = !e.st && !rd;
        arr.pc  = e.pc;
        arr.ins = mem(e.pc);
      end
      if (rd) begin
        m_av.delete();
        foreach (m_if[i]) m_if[i].st = 1'b1;
        m_fpc = {rp[31:2], 2'b00};
      end else if (n) begin
        if (m_av.size() > 0) void'(m_av.pop_front());
        if (dlv) m_av.push_back(arr);
      end else if (k) begin
        x.upd = 1'b0;
        if (dlv) m_av.push_back(arr);
      end else begin
        if (dlv) m_av.push_back(arr);
        if (m_av.size() > 0) begin
          hd    = m_av.pop_front();
          x.v   = 1'b1;
          x.pc  = hd.pc;
          x.ins = hd.ins;
        end
      end
      if (acc) begin
        e.pc = m_fpc; e.st = 1'b0;
        m_if.push_back(e);
        m_fpc = m_fpc + 32'd4;
      end
    end
    exp_q.push_back(x);
    if (r) mq.delete();
    else begin
      if (rv) void'(mq.pop_front());
      if (dacc) mq.push_back(ifc.imem_addr);
    end
    @(posedge clk);
  endtask

  // Monitor: compares the IF/ID register after every clock edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        if (x.upd) begin
          chk("fetch_valid", {31'd0, fetch_valid}, {31'd0, x.v});
          if (x.v) begin
            chk("PC_pype0", PC_pype0, x.pc);
            chk("PCp4_pype0", PCp4_pype0, x.pc + 32'd4);
            chk("Instraction_pype", Instraction_pype, x.ins);
          end else begin
            chk("bubble_instr", Instraction_pype, NOPI);
            if (x.rs) begin
              chk("rst_PC_pype0", PC_pype0, 32'd0);
              chk("rst_PCp4_pype0", PCp4_pype0, 32'd0);
            end
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; keep = 1'b0; nop = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    ifc.imem_ready = 1'b0; ifc.imem_rvalid = 1'b0; ifc.imem_rdata = 32'd0;
    m_fpc = RST_PC;

    repeat (2) step(1, 0, 0, 0, 0, 1, 100);
    repeat (8) step(0, 0, 0, 0, 0, 1, 100);
    repeat (3) step(0, 0, 0, 0, 1, 1, 100);
    repeat (6) step(0, 0, 0, 0, 0, 1, 100);
    step(0, 1, 32'h0000_0200, 0, 0, 1, 100);
    repeat (6) step(0, 0, 0, 0, 0, 1, 100);
    step(0, 1, 32'h0000_0203, 0, 0, 1, 100);
    repeat (5) step(0, 0, 0, 0, 0, 1, 100);
    step(0, 0, 0, 1, 0, 1, 100);
    repeat (5) step(0, 0, 0, 0, 0, 1, 100);
    step(0, 1, 32'hFFFF_FFF4, 0, 0, 1, 100);
    step(0, 0, 0, 0, 0, 1, 100);
    repeat (4) step(0, 0, 0, 0, 0, 0, 100);
    repeat (8) step(0, 0, 0, 0, 0, 1, 100);
    step(1, 0, 0, 0, 0, 1, 100);
    repeat (5) step(0, 0, 0, 0, 0, 1, 100);

    repeat (3000) begin
      step($urandom_range(999) < 5, $urandom_range(99) < 3, $urandom,
           $urandom_range(99) < 5, $urandom_range(99) < 15,
           $urandom_range(99) < 70, 60);
    end
    repeat (4) step(0, 0, 0, 0, 0, 1, 100);
    @(posedge clk);
    #5;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage of the 5-stage RV32I pipeline; producer side of the IF/ID interface that the decode stage consumes.
- Generates the sequential PC and issues requests to instruction memory over a valid/ready request channel with a separate response channel.
- Buffers returned instructions in a small FIFO and drives the IF/ID pipeline register (PC_pype0, PCp4_pype0, Instraction_pype).
- Honours decode-side keep (stall) and nop (flush), plus redirect from branch/jump/trap logic.

Parameters:
RESET_PC, 32'h0000_0000, PC fetched first after reset
FIFO_DEPTH, 2, response buffer entries (power of 2, >=2)
MAX_OUTSTANDING, 2, maximum in-flight imem requests
NOP_INSTR, 32'h0000_0013, instruction word driven on a bubble (addi x0,x0,0)

Ports:
clk  in  1  clock
rst  in  1  reset; one clock; reset is synchronous and active-high
keep  in  1  decode stall: hold the IF/ID register
nop  in  1  flush: load a bubble into the IF/ID register
redirect_valid  in  1  control-flow change this cycle
redirect_pc  in  32  redirect target; bits [1:0] ignored (forced 00)
imem_req  out  1  request valid
imem_addr  out  32  request word address
imem_ready  in  1  memory accepts request; accept = imem_req & imem_ready
imem_rvalid  in  1  response valid; responses in request order
imem_rdata  in  32  response instruction
PC_pype0  out  32  IF/ID PC
PCp4_pype0  out  32  IF/ID PC+4
Instraction_pype  out  32  IF/ID instruction
fetch_valid  out  1  IF/ID register holds a real instruction

Behaviour:
- State: fetch_pc (next request address), O (in-flight count, 0..MAX_OUTSTANDING), D (in-flight responses to drop, D<=O), FIFO of {pc,instr} with count C, IF/ID register.
- Reset (rst=1 at posedge): fetch_pc<=RESET_PC; O,D,C<=0; PC_pype0=0, PCp4_pype0=0, Instraction_pype=NOP_INSTR, fetch_valid=0; imem_req=0 during rst cycle. imem_rvalid with O==0 is ignored.
- Request: imem_req = !rst & !redirect_valid & (O-D+C < FIFO_DEPTH) & (O < MAX_OUTSTANDING); imem_addr=fetch_pc. On accept: fetch_pc<=fetch_pc+4 (mod 2^32; 0xFFFF_FFFC wraps to 0), O increments, request PC is recorded in an in-order PC queue.
- Response: on imem_rvalid, O decrements. If D>0: D decrements, data discarded. Else the entry {pc,rdata} is delivered.
- IF/ID update priority per posedge: rst > redirect_valid > nop > keep > normal.
  - redirect_valid: FIFO and PC queue cleared, C<=0; IF/ID <= bubble; fetch_pc<={redirect_pc[31:2],2'b00}; D <= O - imem_rvalid; response arriving this cycle discarded.
  - nop: IF/ID <= bubble; FIFO head popped if C>0, otherwise bypass response discarded from IF/ID but still pushed to the FIFO.
  - keep: IF/ID holds all values; a delivered response is pushed into the FIFO.
  - normal: if C>0, load FIFO head into IF/ID and pop; a delivered response same cycle is pushed. If C==0 and a response is delivered, bypass directly into IF/ID. Otherwise load bubble.
- IF/ID load: PC_pype0=pc, PCp4_pype0=pc+4 (32-bit wrap), Instraction_pype=instr, fetch_valid=1.
- Credit rule guarantees no FIFO overflow; simultaneous push and pop at C==FIFO_DEPTH is legal.
- Latency (1-cycle memory, imem_ready=1, no stall): redirect in cycle N, request in N+1, response in N+2, valid at decode inputs in N+3; steady throughput 1 instruction/cycle.
- imem_ready low: imem_req and imem_addr held stable until accept, unless redirect_valid or rst.
- rst asserted mid-operation: all state returns to reset values next cycle; the memory is reset by the same rst.

Test Plan:
- Reset, then imem_ready=1 with 1-cycle memory returning addr as data -> imem_addr 0,4,8...; fetch_valid first high 3 cycles after rst deasserts; PC_pype0=0, PCp4_pype0=4, Instraction_pype=0.
- Steady stream, then keep high for 3 cycles -> IF/ID frozen at PC 0x10; FIFO fills (C=2); imem_req drops; on release, PCs 0x14,0x18 appear on consecutive cycles with no gap or duplicate.
- Redirect to 0x200 while O=2 -> both stale responses dropped; next fetch_valid shows PC_pype0=0x200, Instraction_pype=mem[0x200]; no 0x8/0xC leaks.
- Redirect with redirect_pc=0x203 and imem_rvalid in the same cycle -> arriving response dropped; next request address is 0x200.
- nop for one cycle mid-stream -> one bubble (Instraction_pype=0x13, fetch_valid=0); the following instruction is not lost.
- imem_ready low for 4 cycles -> imem_req and imem_addr stable; fetch_pc=0xFFFF_FFFC wraps to 0x0 on the next request; PCp4_pype0=0 for that instruction.
